pixel_out_streamer: RTL and testbench

Memory-mapped pixel transmitter for the RISC-V SoC: the CPU writes pixel bytes over the native picorv32 memory bus, the block buffers them in a synchronous FIFO, and drives them out as a valid/ready byte stream with an end-of-frame marker toward a downstream consumer (display or output link). It is the CPU-to-hardware counterpart of the image engine's readback path and decodes one 16-byte window selected by the SoC address decoder via `mem_sel`.

---
 rtl/pixel_out_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/pixel_out_streamer.sv | 138 +++++++++++++
 tb/tb_pixel_out_streamer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_out_pkg.sv
// Shared definitions for the memory-mapped pixel output streamer.
// Holds register offsets, STATUS/CTRL bit positions and the FIFO entry layout.
package pixel_out_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;

    localparam int unsigned ST_FULL_BIT   = 8;
    localparam int unsigned ST_EMPTY_BIT  = 9;
    localparam int unsigned ST_VALID_BIT  = 10;
    localparam int unsigned ST_FRAMES_LSB = 16;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_FLUSH_BIT = 1;

    localparam int unsigned PIX_W         = 8;
    localparam int unsigned DATA_LAST_BIT = 8;
    localparam int unsigned ENTRY_W       = 9;
    localparam int unsigned FRAMES_W      = 8;

    typedef struct packed {
        logic             last;
        logic [PIX_W-1:0] pixel;
    } pix_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and level count.
// Push on full and pop on empty are ignored; flush wins over both.
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/pixel_out_streamer.sv
// CPU-written pixel bytes buffered in a FIFO and streamed out as valid/ready beats.
// Holds the bus decode, control register, output register stage and frames counter.
module pixel_out_streamer
    import pixel_out_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_sel,
    input  logic [3:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  out_pixel,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready
);

    logic                r_mem_ready;
    logic [31:0]         r_mem_rdata;
    logic                r_enable;
    logic                r_out_valid;
    logic [PIX_W-1:0]    r_out_pixel;
    logic                r_out_last;
    logic [FRAMES_W-1:0] r_frames;

    logic             w_is_write;
    logic             w_accept;
    logic             w_push;
    logic             w_flush;
    logic             w_load;
    logic             w_handshake;
    logic             w_ctrl_wr;
    logic [31:0]      w_rdata;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [LVL_W-1:0] w_level;
    pix_entry_t       w_din;
    pix_entry_t       w_head;
    logic             w_unused;

    assign w_is_write  = |mem_wstrb;
    // A DATA write to a full FIFO is held off; full is the pre-pop state.
    assign w_accept    = mem_sel && !r_mem_ready &&
                         !(w_is_write && (mem_addr == REG_DATA) && w_fifo_full);
    assign w_push      = w_accept && w_is_write && (mem_addr == REG_DATA);
    assign w_ctrl_wr   = w_accept && w_is_write && (mem_addr == REG_CTRL);
    assign w_flush     = w_ctrl_wr && mem_wdata[CTRL_FLUSH_BIT];
    assign w_handshake = r_out_valid && out_ready;
    assign w_load      = r_enable && !w_fifo_empty && (!r_out_valid || out_ready) && !w_flush;

    assign w_din.last  = mem_wdata[DATA_LAST_BIT];
    assign w_din.pixel = mem_wdata[PIX_W-1:0];
    assign w_unused    = ^mem_wdata[31:ENTRY_W];

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_load),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_level)
    );

    // Read mux; DATA, unmapped offsets and writes all return zero.
    always_comb begin
        w_rdata = '0;
        if (!w_is_write) begin
            case (mem_addr)
                REG_STATUS: begin
                    w_rdata[LVL_W-1:0]                           = w_level;
                    w_rdata[ST_FULL_BIT]                         = w_fifo_full;
                    w_rdata[ST_EMPTY_BIT]                        = w_fifo_empty;
                    w_rdata[ST_VALID_BIT]                        = r_out_valid;
                    w_rdata[ST_FRAMES_LSB +: FRAMES_W]           = r_frames;
                end
                REG_CTRL: w_rdata[CTRL_EN_BIT] = r_enable;
                default:  w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
            r_enable    <= 1'b0;
        end else begin
            r_mem_ready <= w_accept;
            r_mem_rdata <= w_accept ? w_rdata : '0;
            if (w_ctrl_wr) r_enable <= mem_wdata[CTRL_EN_BIT];
        end
    end

    // Output stage: a pending beat holds until taken or flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_last  <= 1'b0;
        end else if (w_flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_pixel <= w_head.pixel;
            r_out_last  <= w_head.last;
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frames <= '0;
        end else if (w_handshake && r_out_last) begin
            r_frames <= r_frames + FRAMES_W'(1);
        end
    end

    assign mem_ready = r_mem_ready;
    assign mem_rdata = r_mem_rdata;
    assign out_pixel = r_out_pixel;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_pixel_out_streamer.sv
// Directed-plus-random bench for pixel_out_streamer; expected beats come from a
// queue of written pixels and frames from counting emitted last flags.
module tb_pixel_out_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_sel;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [7:0]  out_pixel;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    pixel_out_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .out_pixel (out_pixel),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [8:0]  exp_q[$];
    int          exp_frames = 0;
    logic        rand_ready = 1'b0;

    logic        s_ready, s_valid, s_last, prev_ready;
    logic [31:0] s_rdata;
    logic [7:0]  s_pixel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status(input int lvl, input bit full, input bit empty,
                                           input bit valid);
        logic [31:0] v;
        logic [7:0]  f;
        f = 8'(exp_frames);
        v = 32'(lvl) | (32'(full) << 8) | (32'(empty) << 9) | (32'(valid) << 10) | (32'(f) << 16);
        return v;
    endfunction

    // One clock: sample at negedge, score any beat, then step to just after posedge.
    task automatic tick();
        logic [8:0] e;
        @(negedge clk);
        s_ready = mem_ready;
        s_rdata = mem_rdata;
        s_valid = out_valid;
        s_pixel = out_pixel;
        s_last  = out_last;
        if (prev_ready) check("ready_single_cycle", 32'(s_ready), 32'd0);
        prev_ready = s_ready;
        if (s_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("beat", 32'({s_last, s_pixel}), 32'(e));
                if (e[8]) exp_frames++;
            end
        end
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic bus(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output int lat);
        mem_sel = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!s_ready && lat < 200);
        if (!s_ready) check("bus_timeout", 32'(s_ready), 32'd1);
        rd = s_rdata;
        mem_sel = 1'b0; mem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int          lat;
        if (a == 4'h0) exp_q.push_back(d[8:0]);
        bus(a, d, 4'hF, rd, lat);
    endtask

    task automatic rdchk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int          lat;
        bus(a, 32'h0, 4'h0, rd, lat);
        check(tag, rd, exp);
    endtask

    task automatic drain();
        int n;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 600) begin
            tick();
            n++;
        end
        check("drain_all", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  hold_pix;
        int          lat;
        int          frames_before;

        rst = 1'b1; mem_sel = 1'b0; mem_addr = 4'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        out_ready = 1'b0; prev_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and first read latency
        tick();
        check("rst_mem_ready", 32'(s_ready), 32'd0);
        check("rst_mem_rdata", s_rdata, 32'd0);
        check("rst_out_valid", 32'(s_valid), 32'd0);
        check("rst_out_pixel", 32'(s_pixel), 32'd0);
        check("rst_out_last", 32'(s_last), 32'd0);
        bus(4'h4, 32'h0, 4'h0, rd, lat);
        check("rst_status", rd, 32'h0000_0200);
        check("read_latency", 32'(lat), 32'd2);
        rdchk("rst_ctrl", 4'h8, 32'h0);
        rdchk("data_reads_zero", 4'h0, 32'h0);
        wr(4'hC, 32'hFFFF_FFFF);
        rdchk("unmapped_reads_zero", 4'hC, 32'h0);
        rdchk("unmapped_write_ignored", 4'h8, 32'h0);

        // Basic stream with a frame end on the last pixel
        out_ready = 1'b1;
        wr(4'h8, 32'h1);
        wr(4'h0, 32'h11);
        wr(4'h0, 32'h22);
        wr(4'h0, 32'h133);
        drain();
        check("frames_after_first", 32'(exp_frames), 32'd1);
        rdchk("status_frames1", 4'h4, 32'h0001_0200);

        // Random pixels under random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) wr(4'h0, 32'($urandom_range(0, 511)));
        drain();
        rdchk("status_after_random", 4'h4, status(0, 0, 1, 0));

        // Pending beat holds across enable clear until taken
        out_ready = 1'b0;
        wr(4'h0, {23'h0, 1'b0, 8'hA5});
        wr(4'h0, {23'h0, 1'b0, 8'h5A});
        tick();
        check("hold_valid_set", 32'(s_valid), 32'd1);
        hold_pix = s_pixel;
        check("hold_first_pixel", 32'(hold_pix), 32'hA5);
        wr(4'h8, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_valid", 32'(s_valid), 32'd1);
            check("hold_pixel", 32'(s_pixel), 32'(hold_pix));
        end
        out_ready = 1'b1;
        tick();
        tick();
        check("hold_released", 32'(s_valid), 32'd0);
        rdchk("hold_status", 4'h4, status(1, 0, 0, 0));

        // Flush with level 5 and a beat pending
        out_ready = 1'b0;
        wr(4'h8, 32'h1);
        for (int i = 0; i < 5; i++) wr(4'h0, 32'($urandom_range(0, 511)));
        rdchk("preflush_status", 4'h4, status(5, 0, 0, 1));
        wr(4'h8, 32'h3);
        check("flush_valid_cleared", 32'(s_valid), 32'd0);
        exp_q.delete();
        rdchk("postflush_status", 4'h4, status(0, 0, 1, 0));
        rdchk("postflush_ctrl", 4'h8, 32'h1);
        wr(4'h0, 32'h1C3);
        check("push_not_yet_valid", 32'(s_valid), 32'd0);
        tick();
        check("push_valid_t2", 32'(s_valid), 32'd1);
        drain();

        // Full FIFO stalls the 17th write until space frees
        out_ready = 1'b0;
        wr(4'h8, 32'h0);
        for (int i = 0; i < 16; i++) wr(4'h0, 32'($urandom_range(0, 511)));
        rdchk("full_status", 4'h4, status(16, 1, 0, 0));
        mem_sel = 1'b1; mem_addr = 4'h0; mem_wdata = 32'h0EE; mem_wstrb = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stall_no_ready", 32'(s_ready), 32'd0);
        end
        mem_sel = 1'b0; mem_wstrb = 4'h0;
        tick();
        rdchk("stall_no_push", 4'h4, status(16, 1, 0, 0));
        out_ready = 1'b1;
        wr(4'h8, 32'h1);
        wr(4'h0, 32'h0EE);
        drain();

        // 256 single-pixel frames wrap the counter back to its start
        frames_before = exp_frames;
        for (int i = 0; i < 256; i++) wr(4'h0, 32'h100 | 32'($urandom_range(0, 255)));
        drain();
        check("frames_model_wrap", 32'(8'(exp_frames)), 32'(8'(frames_before)));
        rdchk("frames_wrap_status", 4'h4, status(0, 0, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
